// File: rtl/register_write_arbiter_if.sv
// Handshake/bus bundle between the requesters and the write arbiter.
// The slave side is the arbiter; the master side is the requester logic.
interface register_write_arbiter_if #(
  parameter int N = 4,
  parameter int R = 4
);
  localparam int GW = $clog2(R);

  logic [R-1:0]   req;
  logic [R*N-1:0] data;
  logic [R-1:0]   ack;
  logic [N-1:0]   reg_d;
  logic           reg_en;
  logic [GW-1:0]  grant_id;
  logic           busy;

  modport master (
    output req, data,
    input  ack, reg_d, reg_en, grant_id, busy
  );

  modport slave (
    input  req, data,
    output ack, reg_d, reg_en, grant_id, busy
  );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter for one shared enable-gated register.
// IDLE picks a winner starting at ptr; GRANT drives D/en and ack for one cycle.
// All outputs come straight from flops.

// Per-requester qualifier: request sits at or above the rotating pointer.
module rwa_lane #(
  parameter int PW  = 2,
  parameter int IDX = 0
) (
  input  logic [PW-1:0] i_ptr,
  input  logic          i_req,
  output logic          o_hi
);
  localparam logic [PW-1:0] L_IDX = PW'(IDX);

  assign o_hi = i_req && (L_IDX >= i_ptr);
endmodule

module register_write_arbiter #(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  register_write_arbiter_if.slave  bus
);
  localparam int PW = $clog2(R);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          r_state, w_state_nx;
  logic [PW-1:0]   r_ptr, w_ptr_nx;
  logic [R-1:0]    r_ack, w_ack_nx;
  logic            r_en, w_en_nx;
  logic [N-1:0]    r_d, w_d_nx;
  logic [PW-1:0]   r_gid, w_gid_nx;
  logic            r_busy, w_busy_nx;

  logic [R-1:0]    w_hi;
  logic            w_found_hi, w_found_lo;
  logic [PW-1:0]   w_g_hi, w_g_lo, w_g;
  logic [N-1:0]    w_sel_d;

  // Mask of requests in the upper (higher-priority) segment of the rotation.
  for (genvar i = 0; i < R; i++) begin : g_lane
    rwa_lane #(.PW(PW), .IDX(i)) u_lane (
      .i_ptr (r_ptr),
      .i_req (bus.req[i]),
      .o_hi  (w_hi[i])
    );
  end

  // Winner: lowest index at/above ptr, else lowest index overall (wrap).
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_g_hi     = '0;
    w_g_lo     = '0;
    for (int i = 0; i < R; i++) begin
      if (w_hi[i] && !w_found_hi) begin
        w_g_hi     = PW'(i);
        w_found_hi = 1'b1;
      end
      if (bus.req[i] && !w_found_lo) begin
        w_g_lo     = PW'(i);
        w_found_lo = 1'b1;
      end
    end
    w_g = w_found_hi ? w_g_hi : w_g_lo;
  end

  // Write data of the winner, sampled only at the IDLE decision edge.
  always_comb begin
    w_sel_d = '0;
    for (int i = 0; i < R; i++)
      if (w_g == PW'(i)) w_sel_d = bus.data[i*N +: N];
  end

  // Next state and next registered outputs; GRANT always returns to IDLE.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_ack_nx   = '0;
    w_en_nx    = 1'b0;
    w_d_nx     = r_d;
    w_gid_nx   = r_gid;
    w_busy_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nx    = GRANT;
          w_ack_nx[w_g] = 1'b1;
          w_en_nx       = 1'b1;
          w_d_nx        = w_sel_d;
          w_gid_nx      = w_g;
          w_busy_nx     = 1'b1;
          w_ptr_nx      = (w_g == PW'(R-1)) ? '0 : w_g + 1'b1;
        end
      end
      GRANT: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // State and output flops; async reset aborts an in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_ack   <= '0;
      r_en    <= 1'b0;
      r_d     <= '0;
      r_gid   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_ack   <= w_ack_nx;
      r_en    <= w_en_nx;
      r_d     <= w_d_nx;
      r_gid   <= w_gid_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.reg_en   = r_en;
  assign bus.reg_d    = r_d;
  assign bus.grant_id = r_gid;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter: directed stimulus pushes expected grants
// into a queue; a monitor pops and compares on every reg_en pulse.
module tb_register_write_arbiter;
  logic clk = 1'b0;
  logic rst;

  register_write_arbiter_if #(.N(4), .R(4)) bus ();

  register_write_arbiter #(.N(4), .R(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared register model: D/en flop, deliberately not reset by the arbiter.
  logic [3:0] q = 4'h0;
  always @(posedge clk) if (bus.reg_en) q <= bus.reg_d;

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] d;
    logic [1:0] gid;
  } exp_t;

  exp_t q_exp[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic prev_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [3:0] d);
    exp_t e;
    e.ack = 4'b0001 << g;
    e.d   = d;
    e.gid = 2'(g);
    q_exp.push_back(e);
  endtask

  // Monitor: compare each write pulse against the oldest expected grant.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.reg_en || (bus.ack != 4'b0)) begin
      chk("ack_en_pair", {31'b0, |bus.ack}, {31'b0, bus.reg_en});
      chk("back_to_back", {31'b0, prev_en}, 32'd0);
      if (q_exp.size() == 0) begin
        chk("unexpected_grant", {28'b0, bus.ack}, 32'd0);
      end else begin
        e = q_exp.pop_front();
        chk("ack", {28'b0, bus.ack}, {28'b0, e.ack});
        chk("reg_d", {28'b0, bus.reg_d}, {28'b0, e.d});
        chk("grant_id", {30'b0, bus.grant_id}, {30'b0, e.gid});
        chk("busy_in_grant", {31'b0, bus.busy}, 32'd1);
      end
    end
    prev_en = bus.reg_en;
  end

  initial begin
    logic [3:0] qv;
    rst      = 1'b0;
    bus.req  = 4'b1111;
    bus.data = 16'h4321;

    // Reset held with all requesting: nothing may be granted.
    repeat (3) @(negedge clk);
    chk("rst_ack", {28'b0, bus.ack}, 32'd0);
    chk("rst_en", {31'b0, bus.reg_en}, 32'd0);
    chk("rst_d", {28'b0, bus.reg_d}, 32'd0);
    chk("rst_gid", {30'b0, bus.grant_id}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    push(0, 4'h1);
    rst = 1'b1;
    @(negedge clk);
    bus.req = 4'b0000;
    chk("t1_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("t1_q", {28'b0, q}, 32'h1);
    chk("t1_en_low", {31'b0, bus.reg_en}, 32'd0);

    // Single write from requester 2.
    bus.req = 4'b0100;
    bus.data[8 +: 4] = 4'hA;
    push(2, 4'hA);
    @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t2_q", {28'b0, q}, 32'hA);
    chk("t2_gid_hold", {30'b0, bus.grant_id}, 32'd2);
    chk("t2_busy_low", {31'b0, bus.busy}, 32'd0);

    // Wrap-around: ptr=3, requesters 3 and 0 -> 3 then 0.
    bus.data[12 +: 4] = 4'hC;
    bus.data[0 +: 4]  = 4'h1;
    bus.req = 4'b1001;
    push(3, 4'hC);
    push(0, 4'h1);
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    chk("t4_q3", {28'b0, q}, 32'hC);
    @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t4_q0", {28'b0, q}, 32'h1);

    // Round-robin from a fresh pointer: all four held high.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.data = 16'h8765;
    bus.req  = 4'b1111;
    push(0, 4'h5); push(1, 4'h6); push(2, 4'h7); push(3, 4'h8); push(0, 4'h5);
    repeat (9) @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t3_q", {28'b0, q}, 32'h5);
    @(negedge clk);

    // Async reset in the middle of a grant of requester 1.
    bus.req = 4'b0010;
    push(1, 4'h6);
    qv = q;
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.req = 4'b0000;
    #1;
    chk("t5_ack_drop", {28'b0, bus.ack}, 32'd0);
    chk("t5_en_drop", {31'b0, bus.reg_en}, 32'd0);
    chk("t5_busy_drop", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_q_unwritten", {28'b0, q}, {28'b0, qv});
    chk("t5_idle", {31'b0, bus.busy}, 32'd0);
    rst = 1'b1;
    bus.data = 16'h4321;
    bus.req  = 4'b1111;
    push(0, 4'h1);                 // ptr back at 0
    @(negedge clk);

    // Late request from requester 1 during grant of 0; its data changes.
    bus.req = 4'b0010;
    bus.data[4 +: 4] = 4'h3;
    chk("t6_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("t6_not_in_grant", {31'b0, bus.reg_en}, 32'd0);
    chk("t6_q0", {28'b0, q}, 32'h1);
    bus.data[4 +: 4] = 4'h6;
    push(1, 4'h6);
    @(negedge clk);
    bus.req = 4'b0000;
    chk("t6_reg_d", {28'b0, bus.reg_d}, 32'h6);
    @(negedge clk);
    chk("t6_q1", {28'b0, q}, 32'h6);

    repeat (3) @(negedge clk);
    chk("queue_empty", q_exp.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Round-robin write arbiter that shares one N-bit enable-gated register (D/en/Q) among R requesters.
- Each requester raises req with its write data. The arbiter picks one requester, drives the register's D and en for exactly one cycle, and returns a one-cycle ack.
- Sits between requester logic and the shared register, and is the only driver of that register's D/en.

Parameters:
- N, 4, data width of the shared register.
- R, 4, number of requesters (2..8).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  R  per-requester write request, bit i = requester i.
- data  input  R*N  packed write data, requester i at bits [i*N +: N].
- ack  output  R  one-hot, one-cycle write acknowledge.
- reg_d  output  N  data to shared register D.
- reg_en  output  1  enable to shared register.
- grant_id  output  $clog2(R)  index of the requester currently or last granted.
- busy  output  1  high while in GRANT state.

Behaviour:
- All outputs are registered; there are no combinational input-to-output paths.
- Reset (rst=0, asynchronous):
  - state=IDLE, ptr=0, ack=0, reg_en=0, reg_d=0, grant_id=0, busy=0.
  - Reset takes effect immediately, mid-grant included: any pending ack/reg_en is cleared and that write does not occur.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE; ack=0, reg_en=0.
  - Else select winner g = first index i with req[i]=1, scanning ptr, ptr+1, ..., R-1, 0, ..., ptr-1.
  - On that edge: state<=GRANT, ack<=one-hot(g), reg_en<=1, reg_d<=data[g], grant_id<=g, busy<=1, ptr<=(g+1) mod R (wraps R-1 -> 0).
- GRANT (lasts exactly one cycle):
  - Next edge: state<=IDLE, ack<=0, reg_en<=0, busy<=0.
  - reg_d and grant_id hold their values.
  - req is ignored in GRANT.
- Register capture: the shared register captures reg_d on the edge that ends GRANT.
  - Latency from req sampled high to register Q updated is 2 edges.
- Requester handshake:
  - A requester keeps req and data stable until it samples ack[i]=1, then deasserts req on that same edge.
  - A requester that still holds req on the following IDLE edge is treated as a new request, with lowest priority because of ptr.
- Throughput: at most one write per 2 cycles; no back-to-back GRANT.
- Fairness: with all R requesting continuously, grants rotate ptr order; each requester waits at most R-1 other grants.
- Data changes while not granted are ignored; only data[g] at the IDLE decision edge is captured.
- Requests that rise during GRANT are first considered at the next IDLE edge.
- ack is never multi-hot; ack and reg_en are always asserted together.

Test Plan:
- Reset: hold rst=0 with req=4'b1111. Expect ack=0, reg_en=0, reg_d=0, grant_id=0, busy=0 throughout. Release rst; the first grant goes to requester 0.
- Single write: req=4'b0100, data[2]=4'hA. Next edge: ack=4'b0100, reg_en=1, reg_d=4'hA, grant_id=2. Edge after: reg_en=0 and register Q=4'hA. ptr=3.
- Round-robin: all req held high, data[i]=i+5. Grants go 0,1,2,3,0 on alternate cycles; reg_d sequence is 5,6,7,8,5; reg_en is never high on two consecutive cycles.
- Wrap-around: set ptr=3 by granting requester 2, then req=4'b1001. Requester 3 is granted first, then requester 0 (ptr wraps to 0).
- Async reset mid-grant: assert rst=0 during the GRANT cycle, between edges. ack and reg_en drop immediately, the register is not written, and after release state=IDLE, ptr=0.
- Late/changing request: req[1] rises during GRANT of requester 0 and is not granted until the next IDLE edge. data[1] changes from 4'h3 to 4'h6 before that edge; reg_d=4'h6.
